// File: rtl/normalize_cg2_pkg.sv
// Shared widths, anchor position and primitive cell costs for the MAC normalizer.
package normalize_cg2_pkg;

  localparam int SUM_W  = 19;
  localparam int MAN_W  = 3;
  localparam int EXP_W  = 6;
  localparam int ANCHOR = 13;
  localparam int QF_W   = 5;
  localparam int POS_W  = $clog2(SUM_W);
  localparam int E_W    = EXP_W + 2;
  localparam int NUM_W  = 51;

  localparam int COST_INV  = 1;
  localparam int COST_OR2  = 2;
  localparam int COST_MX   = 3;
  localparam int COST_ADD  = 12;
  localparam int COST_SUB  = 12;
  localparam int COST_COM6 = 8;
  localparam int COST_EQ6  = 6;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
    logic             zero;
  } result_t;

  localparam int RES_W = $bits(result_t);

  function automatic logic rne_up(input logic lsb, input logic g, input logic s);
    return g & (s | lsb);
  endfunction

endpackage

// File: rtl/normalize_cg2_lzd.sv
// Leading-one detector over the magnitude: priority MX chain plus OR2 reduction for the zero flag.
module lzd_sum
  import normalize_cg2_pkg::*;
(
  input  logic [SUM_W-1:0] vec,
  output logic [POS_W-1:0] pos,
  output logic             all_zero,
  output logic [NUM_W-1:0] number
);

  // Higher bits overwrite lower ones, so the last hit is the leading one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (vec[i]) pos = POS_W'(i);
    end
  end

  assign all_zero = ~|vec;
  assign number   = NUM_W'(SUM_W * COST_MX + (SUM_W - 1) * COST_OR2 + COST_INV);

endmodule

// File: rtl/normalize_cg2.sv
// Two-stage normalizer: two's-complement sum -> sign/magnitude/LZD, then shift, RNE round,
// exponent adjust with underflow flush and overflow saturation.
module normalize_cg2
  import normalize_cg2_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [EXP_W-1:0] i_max_exp,
  input  logic [QF_W-1:0]  i_Q_frac,
  output logic             o_valid,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W-1:0] o_frac,
  output logic             o_zero,
  output logic [QF_W-1:0]  o_Q_frac,
  output logic [NUM_W-1:0] number
);

  localparam int TOP_COST =
      SUM_W * COST_INV + COST_ADD + SUM_W * COST_MX        // negate and select
    + COST_SUB + POS_W * SUM_W * COST_MX                   // shift amount and barrel
    + (SUM_W - MAN_W - 3) * COST_OR2 + COST_ADD            // sticky and round increment
    + COST_EQ6 + 3 * COST_ADD + 2 * COST_COM6              // exponent path and range checks
    + 2 * RES_W * COST_MX;                                 // result selection

  // Stage 1 combinational
  logic             sign_in;
  logic [SUM_W-1:0] neg_in, mag_in;
  logic [POS_W-1:0] pos_in;
  logic             zero_in;
  logic [NUM_W-1:0] lzd_number;

  assign sign_in = i_sum[SUM_W-1];
  assign neg_in  = ~i_sum + SUM_W'(1);
  assign mag_in  = sign_in ? neg_in : i_sum;

  lzd_sum u_lzd (
    .vec      (mag_in),
    .pos      (pos_in),
    .all_zero (zero_in),
    .number   (lzd_number)
  );

  logic             s1_valid, s1_sign, s1_zero;
  logic [SUM_W-1:0] s1_mag;
  logic [POS_W-1:0] s1_pos;
  logic [EXP_W-1:0] s1_max_exp;
  logic [QF_W-1:0]  s1_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_mag     <= '0;
      s1_pos     <= '0;
      s1_max_exp <= '0;
      s1_q       <= '0;
    end else if (!i_stall) begin
      s1_valid   <= i_valid;
      s1_sign    <= sign_in;
      s1_zero    <= zero_in;
      s1_mag     <= mag_in;
      s1_pos     <= pos_in;
      s1_max_exp <= i_max_exp;
      s1_q       <= i_Q_frac;
    end
  end

  // Stage 2: log2 barrel shift puts the leading one at the MSB
  logic [POS_W-1:0]            shamt;
  logic [POS_W:0][SUM_W-1:0]   sh;
  logic [SUM_W-1:0]            norm;

  assign shamt = POS_W'(SUM_W - 1) - s1_pos;
  assign sh[0] = s1_mag;

  for (genvar k = 0; k < POS_W; k++) begin : g_shift
    assign sh[k+1] = shamt[k] ? (sh[k] << (2 ** k)) : sh[k];
  end

  assign norm = sh[POS_W];

  logic [MAN_W-1:0] frac_t, frac_r;
  logic             g_bit, s_bit, rnd, carry, is_zero;
  logic [E_W-1:0]   e;
  logic             underflow, overflow;
  result_t          res;

  assign frac_t  = norm[SUM_W-2 -: MAN_W];
  assign g_bit   = norm[SUM_W-2-MAN_W];
  assign s_bit   = |norm[SUM_W-3-MAN_W:0];
  assign rnd     = rne_up(frac_t[0], g_bit, s_bit);
  assign {carry, frac_r} = {1'b0, frac_t} + (MAN_W + 1)'(rnd);
  assign is_zero = s1_zero | ~norm[SUM_W-1];

  // Signed exponent in EXP_W+2 bits: bit E_W-1 flags negative, bits above EXP_W flag overflow.
  assign e = E_W'(s1_max_exp) + E_W'(s1_pos) - E_W'(ANCHOR) + E_W'(carry);
  assign underflow = e[E_W-1] | (e == '0);
  assign overflow  = ~e[E_W-1] & (|e[E_W-2:EXP_W]);

  always_comb begin
    res = '0;
    if (is_zero || underflow) begin
      res.zero = 1'b1;
    end else if (overflow) begin
      res.sign = s1_sign;
      res.exp  = '1;
      res.frac = '1;
    end else begin
      res.sign = s1_sign;
      res.exp  = e[EXP_W-1:0];
      res.frac = frac_r;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_sign   <= 1'b0;
      o_exp    <= '0;
      o_frac   <= '0;
      o_zero   <= 1'b0;
      o_Q_frac <= '0;
    end else if (!i_stall) begin
      o_valid  <= s1_valid;
      o_sign   <= res.sign;
      o_exp    <= res.exp;
      o_frac   <= res.frac;
      o_zero   <= res.zero;
      o_Q_frac <= s1_q;
    end
  end

  assign number = NUM_W'(TOP_COST) + lzd_number;

endmodule
